load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit between the EX/MEM pipeline register and a variable-latency, word-addressed data bus. It converts byte/half/word loads and stores into aligned bus transactions with byte enables. It sign- or zero-extends load data and stalls the pipeline until the bus acknowledges. Misaligned accesses and bus timeouts are flagged as one-cycle error pulses for the trap logic.

## Interface
Parameters:
- MAX_WAIT, 255 — maximum cycles bus_req stays high without bus_ack before a timeout (1..255).

Ports:
- clk  in  1  — single clock, rising edge.
- rst  in  1  — reset, synchronous, active-low.
- mem_read  in  1  — load request from EX/MEM.
- mem_write  in  1  — store request from EX/MEM; wins if both are high.
- funct3  in  3  — access size/sign.
- addr  in  32  — byte address (ALU result).
- wdata  in  32  — store data (rs2).
- rdata  out  32  — extended load result, registered.
- stall  out  1  — hold IF/ID, ID/EX and EX/MEM while high.
- misaligned  out  1  — combinational misaligned-access flag.
- bus_err  out  1  — one-cycle timeout pulse, registered.
- bus_req  out  1  — bus request, registered.
- bus_we  out  1  — 1 = write.
- bus_addr  out  32  — {addr[31:2], 2'b00}.
- bus_wdata  out  32  — lane-replicated store data.
- bus_be  out  4  — byte enables.
- bus_ack  in  1  — transfer complete; bus_rdata valid in the same cycle.
- bus_rdata  in  32  — read word.

## Operation
FSM states: IDLE, REQ, DONE, ERR.

- **funct3 decoding:** 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned. 011, 110 and 111 are treated as word. Stores use size only.
- **Misaligned access:** a half access with addr[0]=1, or a word access with addr[1:0]≠0. When this happens in IDLE with a request present:
  - misaligned=1;
  - no bus transaction is issued;
  - stall=0;
  - the state stays IDLE.
- **IDLE with a valid aligned request:**
  - stall=1 combinationally;
  - on the edge, capture bus_addr, bus_we, bus_be, bus_wdata, funct3 and the offset addr[1:0];
  - clear the wait counter, set bus_req=1, go to REQ.
- **Byte enables:**
  - byte: 4'b0001<<off;
  - half: 4'b0011<<off;
  - word: 4'b1111.
- **bus_wdata:**
  - byte: {4{wdata[7:0]}};
  - half: {2{wdata[15:0]}};
  - word: wdata.
- **REQ:**
  - stall=1 and bus outputs are held stable.
  - bus_ack=1 → on the edge: drop bus_req; if a load, rdata ← extract(bus_rdata, off, size) extended per funct3; go to DONE.
  - Otherwise the counter increments. If the counter reaches MAX_WAIT−1 without ack → go to ERR and drop bus_req.
- **DONE:** stall=0 for one cycle (the pipeline advances on this edge), then go to IDLE. Requests are not sampled in DONE.
- **ERR:**
  - bus_err=1 and stall=0 for one cycle;
  - rdata ← 0 if the access was a load;
  - then go to IDLE.
- **Stores:** rdata is unchanged.
- **bus_ack outside REQ:** ignored.

## Timing
- **Reset values** (while rst=0 at an edge):
  - state IDLE;
  - bus_req, bus_we, bus_err, bus_be, bus_addr, bus_wdata and rdata all 0;
  - counter 0.
- **Combinational outputs during reset:** stall and misaligned are forced to 0 while rst=0.
- **Reset mid-transaction:** bus_req drops at the reset edge. A late bus_ack after reset is ignored.
- **Zero-wait access** (ack in the first REQ cycle):
  - the IDLE cycle and one REQ cycle are stalled;
  - the DONE cycle releases;
  - 3 cycles per access in total, 2 stall cycles.
- **Wait states:** each cycle of ack delay adds one stall cycle.
- **Timeout:** bus_req stays high for exactly MAX_WAIT cycles, then bus_err pulses in the following cycle.
- **Load data:** rdata is valid from the DONE cycle and holds until the next load completes or a timeout occurs.
- **Back-to-back accesses:** a new request in the cycle after DONE is accepted normally.
- **Unaligned flag:** misaligned is purely combinational and is valid only in IDLE.

## Test plan
- **LW, zero wait:** LW at 0x100, ack in the first REQ cycle with bus_rdata=0xDEADBEEF → bus_addr=0x100, bus_be=4'b1111, stall high for 2 cycles, rdata=0xDEADBEEF in DONE.
- **LB and LBU lane extraction:** LB at 0x103 with bus_rdata=0x80112233 → bus_be=4'b1000, rdata=0xFFFFFF80. LBU at the same address → 0x00000080.
- **SH lane replication:** SH at 0x202 with wdata=0x0000ABCD, ack after 3 wait cycles → bus_be=4'b1100, bus_wdata=0xABCDABCD, bus_we=1, stall high for 5 cycles, rdata unchanged.
- **Misaligned requests:** LW at 0x101 → misaligned=1, bus_req stays 0, stall=0. LH at 0x001 → same response.
- **Timeout:** MAX_WAIT=4, no ack → bus_req high for exactly 4 cycles, then bus_err=1 for one cycle, rdata=0, state returns to IDLE.
- **Reset mid-transaction:** rst=0 in the second REQ cycle → next cycle all outputs are 0. An ack one cycle later is ignored, and the next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store unit. It turns byte/half/word loads and stores from
//   the EX/MEM register into aligned, word-addressed bus transactions with byte
//   enables. It stalls the pipeline until the bus acknowledges, then sign- or
//   zero-extends load data. Misaligned requests are flagged combinationally and
//   never reach the bus. A bus that does not answer within MAX_WAIT cycles
//   produces a one-cycle bus_err pulse.
//
// Ports
//   clk, rst                : clock (rising edge), synchronous active-low reset
//   mem_read, mem_write     : load / store request (store wins if both are high)
//   funct3, addr, wdata     : access size/sign, byte address, store data
//   rdata                   : registered, extended load result
//   stall                   : hold the upstream pipeline registers
//   misaligned              : combinational misaligned-access flag (IDLE only)
//   bus_err                 : registered one-cycle timeout pulse
//   bus_req, bus_we, bus_addr, bus_wdata, bus_be : registered bus request
//   bus_ack, bus_rdata      : bus completion and read word (same cycle)
module load_store_unit #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    // Access size derived from funct3[1:0]; 11 falls through to word.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    // Last counter value before a timeout is declared.
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    logic        req;
    logic        is_mis;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            SZ_BYTE: byte_enables = 4'b0001 << off;
            SZ_HALF: byte_enables = 4'b0011 << off;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    // Replicate the store data across every lane so the enabled lanes always
    // carry the right bytes regardless of offset.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            SZ_BYTE: lane_wdata = {4{d[7:0]}};
            SZ_HALF: lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    // Pick the addressed lane out of the bus word and extend it; funct3[2]
    // selects zero extension.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3[1:0])
            SZ_BYTE: load_extend = f3[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: load_extend = f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extend = word;
        endcase
    endfunction

    assign req    = mem_read | mem_write;
    assign is_mis = is_misaligned(funct3, addr[1:0]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_err_d   = 1'b0;
        rdata_d     = rdata_q;
        f3_d        = f3_q;
        off_d       = off_q;
        stall       = 1'b0;
        misaligned  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (is_mis) begin
                        misaligned = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = byte_enables(funct3, addr[1:0]);
                        bus_wdata_d = lane_wdata(funct3, wdata);
                        f3_d        = funct3;
                        off_d       = addr[1:0];
                        cnt_d       = 8'd0;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        rdata_d = load_extend(f3_q, off_q, bus_rdata);
                    end
                    state_d = DONE;
                end else if (cnt_q == LAST_WAIT) begin
                    // bus_req has now been high for MAX_WAIT cycles.
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (!bus_we_q) begin
                        rdata_d = 32'd0;
                    end
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!rst) begin
            stall      = 1'b0;
            misaligned = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_err_q   <= 1'b0;
            rdata_q     <= 32'd0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_err_q   <= bus_err_d;
            rdata_q     <= rdata_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
        end
    end

    assign rdata     = rdata_q;
    assign bus_err   = bus_err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, misaligned, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .misaligned(misaligned), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected outputs for the current cycle, set by the stimulus timeline.
    logic        chk_en = 1'b0;
    logic        chk_mis, chk_bus;
    logic        exp_stall, exp_mis, exp_req, exp_err, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] mdl_rdata;

    // Observations accumulated by the compare process.
    int          stall_cnt = 0, req_cnt = 0, err_cnt = 0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model of the access rules.
    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
        if (f3[1:0] == 2'b00)      m_be = 4'(1 << off);
        else if (f3[1:0] == 2'b01) m_be = 4'(3 << off);
        else                       m_be = 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'b00)      m_wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
        else if (f3[1:0] == 2'b01) m_wd = {d[15:0], d[15:0]};
        else                       m_wd = d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * off);
        case (f3)
            3'b000: begin v = v & 32'd255;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'b100: v = v & 32'd255;
            3'b001: begin v = v & 32'd65535; if (v >= 32'd32768) v = v - 32'd65536; end
            3'b101: v = v & 32'd65535;
            default: v = w;
        endcase
        m_load = v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", {31'b0, stall}, {31'b0, exp_stall});
            check("bus_req", {31'b0, bus_req}, {31'b0, exp_req});
            check("bus_err", {31'b0, bus_err}, {31'b0, exp_err});
            check("rdata", rdata, exp_rdata);
            if (chk_mis) check("misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
            if (chk_bus) begin
                check("bus_we", {31'b0, bus_we}, {31'b0, exp_we});
                check("bus_addr", bus_addr, exp_addr);
                check("bus_be", {28'b0, bus_be}, {28'b0, exp_be});
                check("bus_wdata", bus_wdata, exp_wdata);
            end
            if (stall === 1'b1) stall_cnt++;
            if (bus_err === 1'b1) err_cnt++;
            if (bus_req === 1'b1) begin
                req_cnt++;
                last_addr  = bus_addr;
                last_wdata = bus_wdata;
                last_be    = bus_be;
                last_we    = bus_we;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_quiet();
        exp_stall = 1'b0; exp_mis = 1'b0; exp_req = 1'b0; exp_err = 1'b0;
        chk_mis = 1'b1; chk_bus = 1'b0; exp_rdata = mdl_rdata;
    endtask

    // Idle cycles with a stray ack on the bus, which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mem_read = 1'b0; mem_write = 1'b0;
            bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
            set_quiet();
            cyc();
        end
        bus_ack = 1'b0;
    endtask

    task automatic mis_req(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        mem_read = !wr; mem_write = wr; funct3 = f3; addr = a; wdata = 32'h1234_5678;
        bus_ack = 1'b0;
        set_quiet();
        exp_mis = 1'b1;
        cyc();
    endtask

    // One access; ack_dly = wait cycles before ack, negative = never ack.
    task automatic do_access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int ack_dly, input logic [31:0] rd);
        bit acked;
        acked = 0;
        mem_read = !wr; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        bus_ack = 1'b0; bus_rdata = rd;
        set_quiet();
        exp_stall = 1'b1;
        cyc();
        for (int k = 0; k < MAX_WAIT; k++) begin
            bus_ack   = (k == ack_dly);
            exp_stall = 1'b1; chk_mis = 1'b0; exp_req = 1'b1; chk_bus = 1'b1;
            exp_we    = wr;
            exp_addr  = {a[31:2], 2'b00};
            exp_be    = m_be(f3, a[1:0]);
            exp_wdata = m_wd(f3, wd);
            cyc();
            if (k == ack_dly) begin
                acked = 1;
                break;
            end
        end
        bus_ack = 1'b0;
        exp_req = 1'b0; chk_bus = 1'b0; exp_stall = 1'b0;
        if (acked) begin
            if (!wr) mdl_rdata = m_load(f3, a[1:0], rd);
        end else begin
            exp_err = 1'b1;
            if (!wr) mdl_rdata = 32'd0;
        end
        exp_rdata = mdl_rdata;
        cyc();
        exp_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, e0;
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        mdl_rdata = 32'd0;
        set_quiet();
        exp_we = 1'b0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_be = 4'd0;
        cyc();
        // Reset state: everything zero.
        chk_en = 1'b1; chk_bus = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        idle(2);

        // LW zero wait.
        s0 = stall_cnt;
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        check("lw_stall_cycles", 32'(stall_cnt - s0), 32'd2);
        check("lw_bus_addr", last_addr, 32'h0000_0100);
        check("lw_bus_be", {28'b0, last_be}, 32'hF);
        check("lw_rdata", rdata, 32'hDEADBEEF);

        // Back-to-back LB / LBU lane extraction.
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h8011_2233);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        check("lb_bus_be", {28'b0, last_be}, 32'h8);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h8011_2233);
        check("lbu_rdata", rdata, 32'h0000_0080);
        idle(1);

        // SH with three wait cycles.
        s0 = stall_cnt;
        do_access(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 3, 32'hFFFF_FFFF);
        check("sh_stall_cycles", 32'(stall_cnt - s0), 32'd5);
        check("sh_bus_wdata", last_wdata, 32'hABCD_ABCD);
        check("sh_bus_be", {28'b0, last_be}, 32'hC);
        check("sh_bus_we", {31'b0, last_we}, 32'd1);
        check("sh_rdata_kept", rdata, 32'h0000_0080);

        // Misaligned requests never reach the bus.
        r0 = req_cnt;
        mis_req(1'b0, 3'b010, 32'h101);
        mis_req(1'b0, 3'b001, 32'h001);
        mis_req(1'b1, 3'b010, 32'h102);
        idle(1);
        check("mis_no_bus_req", 32'(req_cnt - r0), 32'd0);

        // More sizes, offsets and the 011 word alias.
        do_access(1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h8000_1234);
        check("lhu_rdata", rdata, 32'h0000_8000);
        do_access(1'b0, 3'b001, 32'h102, 32'h0, 2, 32'h8000_1234);
        check("lh_rdata", rdata, 32'hFFFF_8000);
        do_access(1'b1, 3'b000, 32'h001, 32'h0000_005A, 1, 32'h0);
        check("sb_bus_wdata", last_wdata, 32'h5A5A_5A5A);
        check("sb_bus_be", {28'b0, last_be}, 32'h2);
        do_access(1'b1, 3'b010, 32'h010, 32'h1234_5678, 0, 32'h0);
        do_access(1'b0, 3'b011, 32'h008, 32'h0, 2, 32'h0BAD_F00D);
        check("ld_011_rdata", rdata, 32'h0BAD_F00D);
        idle(1);

        // Timeout: no ack.
        r0 = req_cnt; e0 = err_cnt;
        do_access(1'b0, 3'b010, 32'h400, 32'h0, -1, 32'h0);
        check("to_req_cycles", 32'(req_cnt - r0), 32'd4);
        check("to_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("to_rdata", rdata, 32'h0);
        do_access(1'b0, 3'b010, 32'h104, 32'h0, 0, 32'hCAFE_F00D);
        check("after_to_rdata", rdata, 32'hCAFE_F00D);

        // Reset in the second REQ cycle, then a late ack.
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
        bus_ack = 1'b0; bus_rdata = 32'h7777_7777;
        set_quiet(); exp_stall = 1'b1;
        cyc();
        exp_req = 1'b1; chk_mis = 1'b0; chk_bus = 1'b1;
        exp_we = 1'b0; exp_addr = 32'h300; exp_be = 4'hF; exp_wdata = 32'h0;
        cyc();
        rst = 1'b0;
        exp_stall = 1'b0; chk_mis = 1'b1; exp_mis = 1'b0;
        cyc();
        rst = 1'b1; mem_read = 1'b0; bus_ack = 1'b1;
        mdl_rdata = 32'd0;
        set_quiet(); chk_bus = 1'b1;
        exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
        cyc();
        bus_ack = 1'b0;
        set_quiet();
        cyc();
        do_access(1'b0, 3'b010, 32'h500, 32'h0, 0, 32'h1122_3344);
        check("post_rst_rdata", rdata, 32'h1122_3344);
        idle(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
